mult_pipe: RTL and testbench
============================

# mult_pipe

Pipelined, parametrised successor to the single-shot FSM multiplier: accepts one WIDTH×WIDTH multiply per cycle over a ready-valid input channel. Each operation is selectable signed or unsigned. The full 2·WIDTH product is returned in order over a ready-valid output channel. A LATENCY-stage multiplier pipeline feeds a DEPTH-entry output FIFO. Credit-based input flow control guarantees the pipeline never stalls and never drops a result. The block sits between an issue stage and a writeback stage that may apply backpressure.

## Interface
- WIDTH, 32: operand width; legal ≥ 2.
- LATENCY, 3: multiplier pipeline stages; legal 1..8.
- DEPTH, 4: output FIFO entries and maximum operations in flight; power of 2; must be ≥ LATENCY+1 (elaboration-time check, fatal otherwise).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement signed × signed; 0 = unsigned × unsigned; sampled with a/b.
- valid_in  in  1  input operation valid.
- ready_out  out  1  block can accept an operation this cycle.
- lo  out  WIDTH  product bits [WIDTH-1:0].
- hi  out  WIDTH  product bits [2·WIDTH-1:WIDTH].
- valid_out  out  1  lo/hi hold a valid result.
- ready_in  in  1  downstream accepts the result.
- busy  out  1  any operation in flight or queued.

## Operation
- Accept: an operation is accepted on a rising edge where valid_in && ready_out.
- Sampling: a, b and is_signed are sampled on the accept edge. Input values may change freely afterwards.
- Pop: a result is popped on a rising edge where valid_out && ready_in.
- Occupancy counter occ (range 0..DEPTH) counts in-flight pipeline entries plus FIFO entries.
  - +1 on accept, −1 on pop.
  - Both on the same edge: occ unchanged.
- ready_out = (occ < DEPTH). It is derived from registered state only, with no combinational path from ready_in or valid_in.
- Pipeline: a LATENCY-deep valid-tagged shift register. It advances every cycle unconditionally and is never stalled.
  - Stage 1 registers the operands and mode.
  - The product is computed full-width: signed mode sign-extends both operands to 2·WIDTH; unsigned mode zero-extends.
  - The product wraps into 2·WIDTH bits, which is exact for both modes.
- FIFO write: when a valid entry exits the last stage, it is written to the FIFO. The credit scheme guarantees the FIFO is never full at write time. The bench flags an overflow assertion if it is.
- FIFO pointers wrap modulo DEPTH. Simultaneous write and pop on the same edge are both honoured.
- Ordering: results leave strictly in accept order, regardless of is_signed.
- Outputs:
  - valid_out = FIFO not empty.
  - lo/hi = FIFO head when valid_out = 1; forced to 0 when valid_out = 0.
  - lo/hi are stable while valid_out && !ready_in.
- busy = (occ != 0).
- Reset:
  - Asserting rst_n discards all in-flight and queued operations immediately (asynchronous), including mid-pipeline.
  - After deassertion, no stale result ever appears.

## Timing
- Reset values: ready_out=1, valid_out=0, lo=0, hi=0, busy=0, occ=0, all pipeline valid bits 0, FIFO pointers 0.
- No operation is accepted while rst_n=0.
- Latency: an operation accepted on edge k has valid_out=1 with its result from just after edge k+LATENCY. This holds when the FIFO was empty; otherwise the result appears later, behind older results.
- Earliest pop of that result is edge k+LATENCY+1.
- Throughput: 1 op/cycle sustained with ready_in held high, given DEPTH ≥ LATENCY+1.
- Full with backpressure: after DEPTH accepts with no pops, ready_out=0.
  - A pop on edge p raises ready_out just after edge p.
  - The next accept is therefore possible on edge p+1.
  - No same-cycle pass-through of credit.
- busy falls just after the edge that pops the last result.

## Test plan
- Single unsigned op, defaults: a=7, b=6, is_signed=0, accepted edge 0 → valid_out from edge 3, lo=42, hi=0; popped edge 4; busy=0 after.
- Signed vs unsigned, WIDTH=32: a=0xFFFFFFFF, b=2.
  - is_signed=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - is_signed=0 → hi=0x00000001, lo=0xFFFFFFFE.
  - Results emerge in issue order.
- Streaming: 16 back-to-back ops a=i, b=i+1 with ready_in=1 → ready_out never drops; one result per cycle from edge 3; lo=i·(i+1) in order.
- Backpressure: ready_in=0, valid_in=1 continuously, DEPTH=4 → exactly 4 accepts, then ready_out=0.
  - valid_out holds the first result stable.
  - Raise ready_in for one cycle → one pop, ready_out=1 next cycle, one further accept.
- Extreme operands: a=b=0x80000000 signed → hi=0x40000000, lo=0; a=b=0xFFFFFFFF unsigned → hi=0xFFFFFFFE, lo=0x00000001.
- Mid-operation reset: accept 3 ops, assert rst_n low for 1 cycle at edge 2 → all outputs at reset values immediately; no result ever emerges afterwards; a new op a=3, b=5 returns lo=15 with normal latency.

Source files
------------

// File: rtl/mult_pipe.sv
// -----------------------------------------------------------------------------
// mult_pipe
//
// Pipelined WIDTH x WIDTH multiplier. It accepts one operation per cycle and
// returns the full 2*WIDTH-bit product, in accept order, through an output
// FIFO. Each operation can be signed x signed or unsigned x unsigned.
//
// Handshake rules (both channels): a transfer happens on the rising edge where
// valid and ready are both high. The producer holds valid and data until that
// edge. ready is never derived combinationally from the partner's valid.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset; discards everything in flight
//   a, b       operands, sampled on the accept edge
//   is_signed  1 = signed x signed, 0 = unsigned x unsigned, sampled with a/b
//   valid_in   input operation valid
//   ready_out  an operation can be accepted this cycle (registered state only)
//   lo, hi     product bits [WIDTH-1:0] / [2*WIDTH-1:WIDTH]; 0 when idle
//   valid_out  lo/hi hold a result (FIFO not empty)
//   ready_in   downstream takes the result
//   busy       any operation in flight or queued
// -----------------------------------------------------------------------------
module mult_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PRW = 2 * WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // The credit scheme only works if the FIFO can hold every operation
    // that may be in flight. DEPTH must also be a power of two because the
    // FIFO pointers wrap naturally.
    generate
        if (WIDTH < 2 || LATENCY < 1 || LATENCY > 8 || DEPTH < LATENCY + 1 ||
            (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
            $fatal(1, "mult_pipe: illegal WIDTH/LATENCY/DEPTH combination");
        end
    endgenerate

    // ---------------------------------------------------------------- credits
    logic [CW-1:0]  r_occ;
    logic           w_accept;
    logic           w_pop;

    // Set only from registered occupancy. A pop frees a slot starting on the
    // next cycle, so credit never passes through in the same cycle.
    assign ready_out = (r_occ < DEPTH_C);
    assign busy      = (r_occ != '0);
    assign w_accept  = valid_in && ready_out;
    assign w_pop     = valid_out && ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // --------------------------------------------------------------- pipeline
    logic [LATENCY-1:0] r_vld;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic               r_s1_sgn;
    logic [PRW-1:0]     w_ext_a;
    logic [PRW-1:0]     w_ext_b;
    logic [PRW-1:0]     w_prod;
    logic [PRW-1:0]     w_tail_prod;

    // The valid tags advance every cycle. Nothing stalls, because the FIFO
    // always has space for anything that leaves the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_s1_a   <= a;
        r_s1_b   <= b;
        r_s1_sgn <= is_signed;
    end

    // Signed mode sign-extends both operands; unsigned mode zero-extends.
    // The low 2*WIDTH bits of the product are then exact in either mode.
    assign w_ext_a = {{WIDTH{r_s1_sgn & r_s1_a[WIDTH-1]}}, r_s1_a};
    assign w_ext_b = {{WIDTH{r_s1_sgn & r_s1_b[WIDTH-1]}}, r_s1_b};
    assign w_prod  = w_ext_a * w_ext_b;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_tail_prod = w_prod;
        end else begin : g_latn
            logic [PRW-1:0] r_prod [LATENCY-1];
            always_ff @(posedge clk) begin
                r_prod[0] <= w_prod;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_prod[i] <= r_prod[i-1];
                end
            end
            assign w_tail_prod = r_prod[LATENCY-2];
        end
    endgenerate

    // ------------------------------------------------------------ output FIFO
    logic [PRW-1:0] r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_cnt;
    logic           w_wr;
    logic [PRW-1:0] w_head;

    assign w_wr      = r_vld[LATENCY-1];
    assign valid_out = (r_cnt != '0);
    assign w_head    = r_mem[r_rptr];
    assign lo        = valid_out ? w_head[WIDTH-1:0]   : '0;
    assign hi        = valid_out ? w_head[PRW-1:WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_tail_prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // The credit scheme guarantees a free slot for every write.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_wr && r_cnt == DEPTH_C));

endmodule

// File: tb/tb_mult_pipe.sv
module tb_mult_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         valid_out;
    logic         ready_in = 1'b0;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    mult_pipe #(.WIDTH(W), .LATENCY(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .lo        (lo),
        .hi        (hi),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .busy      (busy)
    );

    // ---------------------------------------------------------- clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- checker
    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_rdy"},  64'(ready_out), 64'd1);
        check_eq({tag, "_vld"},  64'(valid_out), 64'd0);
        check_eq({tag, "_lo"},   64'(lo),        64'd0);
        check_eq({tag, "_hi"},   64'(hi),        64'd0);
        check_eq({tag, "_busy"}, 64'(busy),      64'd0);
    endtask

    // Called at a negedge: waits (bounded) for a result, checks and pops it.
    task automatic expect_result(input string tag, input logic [W-1:0] ehi,
                                 input logic [W-1:0] elo);
        int n = 0;
        while (!valid_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_wait"}, 64'(n < 20), 64'd1);
        check_eq({tag, "_hi"},   64'(hi),     64'(ehi));
        check_eq({tag, "_lo"},   64'(lo),     64'(elo));
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
    endtask

    task automatic drive_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vs);
        a         = va;
        b         = vb;
        is_signed = vs;
        valid_in  = 1'b1;
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int n_acc;
        int issued;
        int exp_i;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single unsigned op: 7*6, accepted on edge 0
        drive_op(32'd7, 32'd6, 1'b0);
        @(negedge clk);                     // after edge 0
        valid_in = 1'b0;
        check_eq("t1_busy", 64'(busy), 64'd1);
        check_eq("t1_vld0", 64'(valid_out), 64'd0);
        @(negedge clk);                     // after edge 1
        check_eq("t1_vld1", 64'(valid_out), 64'd0);
        @(negedge clk);                     // after edge 2
        check_eq("t1_vld2", 64'(valid_out), 64'd0);
        @(negedge clk);                     // after edge 3
        check_eq("t1_vld3", 64'(valid_out), 64'd1);
        check_eq("t1_lo",   64'(lo), 64'd42);
        check_eq("t1_hi",   64'(hi), 64'd0);
        ready_in = 1'b1;
        @(negedge clk);                     // popped on edge 4
        ready_in = 1'b0;
        check_eq("t1_vld_after", 64'(valid_out), 64'd0);
        check_eq("t1_busy_after", 64'(busy), 64'd0);

        // Signed vs unsigned, issued back to back
        drive_op(32'hFFFF_FFFF, 32'd2, 1'b1);
        @(negedge clk);
        drive_op(32'hFFFF_FFFF, 32'd2, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        expect_result("sgn_m1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        expect_result("uns_m1x2", 32'h0000_0001, 32'hFFFF_FFFE);

        // Extreme operands
        drive_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        @(negedge clk);
        drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        expect_result("sgn_min2", 32'h4000_0000, 32'h0000_0000);
        expect_result("uns_max2", 32'hFFFF_FFFE, 32'h0000_0001);

        // Streaming: 16 ops a=i, b=i+1, ready_in held high
        ready_in = 1'b1;
        issued = 0;
        exp_i  = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (valid_out) begin
                check_eq("strm_lo", 64'(lo), 64'(exp_i * (exp_i + 1)));
                check_eq("strm_hi", 64'(hi), 64'd0);
                exp_i++;
            end
            if (cyc == 3) check_eq("strm_vld_e2", 64'(valid_out), 64'd0);
            if (cyc == 4) check_eq("strm_vld_e3", 64'(valid_out), 64'd1);
            if (issued < 16) begin
                drive_op(W'(issued), W'(issued + 1), 1'b0);
                // ready_out is registered, so its value now holds at the edge
                if (ready_out) issued++;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
        end
        ready_in = 1'b0;
        check_eq("strm_count", 64'(exp_i), 64'd16);
        check_eq("strm_busy", 64'(busy), 64'd0);

        // Backpressure: ready_in low, valid_in high, a=n+1, b=3
        n_acc = 0;
        for (int n = 0; n < 8; n++) begin
            if (n >= 4) check_eq("bp_hold", 64'(lo), 64'd3);
            drive_op(W'(n + 1), 32'd3, 1'b0);
            if (ready_out) n_acc++;
            @(negedge clk);
        end
        check_eq("bp_accepts", 64'(n_acc), 64'd4);
        check_eq("bp_rdy0", 64'(ready_out), 64'd0);
        check_eq("bp_vld", 64'(valid_out), 64'd1);
        check_eq("bp_lo_held", 64'(lo), 64'd3);
        ready_in = 1'b1;
        drive_op(32'd9, 32'd3, 1'b0);       // not accepted: full
        @(negedge clk);                     // one pop
        ready_in = 1'b0;
        check_eq("bp_rdy1", 64'(ready_out), 64'd1);
        check_eq("bp_lo_next", 64'(lo), 64'd6);
        drive_op(32'd10, 32'd3, 1'b0);      // accepted on this edge
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("bp_rdy_full", 64'(ready_out), 64'd0);
        expect_result("bp_r1", 32'd0, 32'd6);
        expect_result("bp_r2", 32'd0, 32'd9);
        expect_result("bp_r3", 32'd0, 32'd12);
        expect_result("bp_r4", 32'd0, 32'd30);
        check_eq("bp_busy", 64'(busy), 64'd0);

        // Mid-operation reset
        drive_op(32'd1, 32'd1, 1'b0);
        @(negedge clk);
        drive_op(32'd2, 32'd1, 1'b0);
        @(negedge clk);
        drive_op(32'd3, 32'd1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #2;
        check_eq("rst_pre_vld", 64'(valid_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle("rst_async");
        drive_op(32'd9, 32'd9, 1'b0);       // must be ignored while in reset
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check_eq("rst_no_stale", 64'(valid_out), 64'd0);
        end
        ready_in = 1'b0;
        check_eq("rst_busy", 64'(busy), 64'd0);
        drive_op(32'd3, 32'd5, 1'b0);
        @(negedge clk);                     // after accept edge
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_new_vld2", 64'(valid_out), 64'd0);
        @(negedge clk);
        check_eq("rst_new_vld3", 64'(valid_out), 64'd1);
        expect_result("rst_new", 32'd0, 32'd15);
        check_eq("rst_new_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
